fdl_ctrl: RTL

FDL_CTRL -- requirements
Module: fdl_ctrl

---
 rtl/fdl_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/fdl_ctrl.sv
// Fine-delay-line controller: steps a thermometer-coded delay on phase-detector
// requests, hands overflow to the coarse line, and flags lock on steady dithering.
module fdl_ctrl #(
   parameter int unsigned N_STAGES = 6,
   parameter int unsigned UPD_DIV  = 4,
   parameter int unsigned LOCK_CNT = 8
) (
   input  logic                              clk_in,
   input  logic                              rst_n,
   input  logic                              en,
   input  logic                              up,
   input  logic                              dn,
   output logic [N_STAGES-1:0]               Q,
   output logic [$clog2(N_STAGES+1)-1:0]     code,
   output logic                              carry_up,
   output logic                              carry_dn,
   output logic                              locked
);
   localparam int unsigned CW = $clog2(N_STAGES + 1);
   localparam int unsigned DW = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
   localparam int unsigned RW = $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0] MID      = CW'(N_STAGES / 2);
   localparam logic [CW-1:0] TOP      = CW'(N_STAGES);
   localparam logic [DW-1:0] DIV_LAST = DW'(UPD_DIV - 1);
   localparam logic [RW-1:0] LOCK_MAX = RW'(LOCK_CNT);

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_e;

   logic [DW-1:0]       div_q, div_d;
   logic [CW-1:0]       code_d;
   logic [N_STAGES-1:0] q_d;
   logic [RW-1:0]       rev_q, rev_d;
   logic [1:0]          same_q, same_d;
   dir_e                dir_q, dir_d, step_dir;
   logic                carry_up_d, carry_dn_d, locked_d;
   logic                tick, inc, dec;

   function automatic logic [N_STAGES-1:0] therm(input logic [CW-1:0] c);
      therm = '0;
      for (int i = 0; i < int'(N_STAGES); i++) therm[i] = (i < int'(c));
   endfunction

   // State register
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= '0;
         code     <= MID;
         Q        <= therm(MID);
         carry_up <= 1'b0;
         carry_dn <= 1'b0;
         locked   <= 1'b0;
         rev_q    <= '0;
         same_q   <= '0;
         dir_q    <= DIR_NONE;
      end else begin
         div_q    <= div_d;
         code     <= code_d;
         Q        <= q_d;
         carry_up <= carry_up_d;
         carry_dn <= carry_dn_d;
         locked   <= locked_d;
         rev_q    <= rev_d;
         same_q   <= same_d;
         dir_q    <= dir_d;
      end
   end

   // Next-state: divider, code stepping with coarse carry, lock tracking
   always_comb begin
      tick       = en && (div_q == DIV_LAST);
      div_d      = (en && !tick) ? DW'(div_q + DW'(1)) : '0;
      inc        = tick && up && !dn;
      dec        = tick && dn && !up;
      step_dir   = inc ? DIR_UP : DIR_DN;
      code_d     = code;
      carry_up_d = 1'b0;
      carry_dn_d = 1'b0;
      locked_d   = locked;
      rev_d      = rev_q;
      same_d     = same_q;
      dir_d      = dir_q;

      if ((inc && code == TOP) || (dec && code == '0)) begin
         code_d     = MID;
         carry_up_d = inc;
         carry_dn_d = dec;
         locked_d   = 1'b0;
         rev_d      = '0;
         same_d     = '0;
         dir_d      = DIR_NONE;
      end else if (inc || dec) begin
         code_d = inc ? CW'(code + CW'(1)) : CW'(code - CW'(1));
         dir_d  = step_dir;
         if (dir_q == DIR_NONE) begin
            rev_d = rev_q;
         end else if (step_dir != dir_q) begin
            rev_d  = (rev_q == LOCK_MAX) ? rev_q : RW'(rev_q + RW'(1));
            same_d = '0;
            if (rev_d == LOCK_MAX) locked_d = 1'b1;
         end else begin
            same_d = (same_q == 2'd2) ? same_q : 2'(same_q + 2'd1);
            if (!locked) begin
               rev_d = '0;
            end else if (same_d == 2'd2) begin
               // a second consecutive same-direction step breaks lock
               locked_d = 1'b0;
               rev_d    = '0;
               same_d   = '0;
            end
         end
      end
      q_d = therm(code_d);
   end
endmodule
